fir_tx_serializer: RTL and testbench

Buffers parallel FIR output samples and slices each into bytes for the UART transmitter. Sits directly upstream of the async transmitter: consumes samples via a valid/ready handshake and drives the transmitter's data/start inputs while observing its busy flag. Byte-wise, LSB-first transmission keeps the UART path independent of the filter's sample width.

---
 rtl/fir_uart_pkg.sv | 16 +
 rtl/fir_tx_serializer_sample_fifo.sv | 57 +++++
 rtl/fir_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_fir_tx_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_uart_pkg.sv
// Shared types and constants for the FIR-to-UART serializer path.
package fir_uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ARM       = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5
  } tx_state_e;

endpackage

// File: rtl/fir_tx_serializer_sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO holding FIR samples.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign dout  = r_mem[r_rd];
  assign level = r_level;

endmodule

// File: rtl/fir_tx_serializer.sv
// fir_tx_serializer: buffers FIR samples and feeds them LSB byte first to a UART.
// Optional build macro FIR_TX_SYNC_EN prefixes every sample with SYNC_BYTE.
module fir_tx_serializer
  import fir_uart_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUSY_TMO   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        idle
);

  localparam int unsigned NB    = SAMPLE_W / BYTE_W;
`ifdef FIR_TX_SYNC_EN
  localparam int unsigned NBT   = NB + 1;
  localparam int unsigned SH_W  = SAMPLE_W + BYTE_W;
`else
  localparam int unsigned NBT   = NB;
  localparam int unsigned SH_W  = SAMPLE_W;
`endif
  localparam int unsigned CNT_W = $clog2(NBT + 1);
  localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e          r_state, w_state_nxt;
  logic [SH_W-1:0]    r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic [BYTE_W-1:0]  r_tx_data, w_tx_data_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic               r_ready;
  logic               r_idle;
  logic               w_push, w_pop, w_full, w_empty;
  logic [SAMPLE_W-1:0] w_dout;
  logic [LVL_W-1:0]   w_level, w_level_nxt;
  logic [SH_W-1:0]    w_load;

  assign w_push      = sample_valid & r_ready & ~w_full;
  assign w_level_nxt = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

`ifdef FIR_TX_SYNC_EN
  assign w_load = {w_dout, SYNC_BYTE};
`else
  assign w_load = w_dout;
`endif

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (sample_in),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_ready    <= 1'b1;
      r_idle     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_ready    <= (w_level_nxt != LVL_W'(FIFO_DEPTH));
      r_idle     <= (w_state_nxt == ST_IDLE) && (w_level_nxt == '0);
    end
  end

  // Next-state and next-output decode; start is only issued from ARM with the link free.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_cnt_nxt      = r_cnt;
    w_tmo_nxt      = r_tmo;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_pop       = 1'b1;
        w_shreg_nxt = w_load;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (!tx_busy) begin
          w_tx_data_nxt  = r_shreg[BYTE_W-1:0];
          w_tx_start_nxt = 1'b1;
          w_tmo_nxt      = '0;
          w_state_nxt    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_tmo == TMO_W'(BUSY_TMO - 1)) begin
          w_state_nxt = ST_NEXT;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_cnt == CNT_W'(NBT - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_shreg_nxt = r_shreg >> BYTE_W;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = ST_ARM;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sample_ready = r_ready;
  assign tx_data      = r_tx_data;
  assign tx_start     = r_tx_start;
  assign fifo_level   = w_level;
  assign idle         = r_idle;

endmodule

// File: tb/tb_fir_tx_serializer.sv
// Directed bench for fir_tx_serializer with a simple busy-flag transmitter model.
module tb_fir_tx_serializer;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BUSY_TMO   = 4;
  localparam int unsigned NB         = SAMPLE_W / 8;
`ifdef FIR_TX_SYNC_EN
  localparam int unsigned NBT = NB + 1;
`else
  localparam int unsigned NBT = NB;
`endif

  logic                        clk = 1'b0;
  logic                        rst;
  logic [SAMPLE_W-1:0]         sample_in;
  logic                        sample_valid;
  logic                        sample_ready;
  logic [7:0]                  tx_data;
  logic                        tx_start;
  logic                        tx_busy = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        idle;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       prev_start = 1'b0;
  logic [7:0] got[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  fir_tx_serializer #(
    .SAMPLE_W   (SAMPLE_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BUSY_TMO   (BUSY_TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .fifo_level   (fifo_level),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transmitter model: captures each start pulse and holds busy for busy_len cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      check_eq("start_while_busy", 32'(tx_busy), 0);
      check_eq("start_back_to_back", 32'(prev_start), 0);
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
      if (busy_len > 0) begin
        tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    prev_start = tx_start;
  end

  task automatic add_exp(input logic [15:0] s);
`ifdef FIR_TX_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
  endtask

  task automatic clear_all();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // Present a sample and return at the negedge after the edge that accepted it.
  task automatic push_sample(input logic [15:0] s);
    bit acc;
    sample_in    = s;
    sample_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      acc = sample_ready;
      @(negedge clk);
      if (acc) return;
    end
    check_eq("push_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n && idle) return;
      @(negedge clk);
    end
    check_eq("done_timeout", got.size(), n);
  endtask

  task automatic check_bytes(input string tag);
    check_eq({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) check_eq(tag, 32'(got[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(sample_ready), 1);
    check_eq({tag, "_data"},  32'(tx_data), 0);
    check_eq({tag, "_start"}, 32'(tx_start), 0);
    check_eq({tag, "_level"}, 32'(fifo_level), 0);
    check_eq({tag, "_idle"},  32'(idle), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] s6 [6];
    int c0;
    int n0;
    int gap;
    s6 = '{16'hA1B1, 16'hC2D2, 16'hE3F3, 16'h0414, 16'h2535, 16'h4656};

    rst          = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single sample, long busy: byte order, latency, idle afterwards.
    busy_len = 20;
    clear_all();
    add_exp(16'h1234);
    push_sample(16'h1234);
    sample_valid = 1'b0;
    c0 = cyc;
    wait_done(NBT, 400);
    check_bytes("single_byte");
    if (got_cyc.size() >= 1) check_eq("single_latency", got_cyc[0] - c0, 3);
    if (got_cyc.size() >= 2) begin
      gap = got_cyc[1] - got_cyc[0];
      check_eq("single_gap_after_busy", 32'(gap >= 22), 1);
    end
    check_eq("single_idle", 32'(idle), 1);
    check_eq("single_level", 32'(fifo_level), 0);

    // Six samples back-to-back into a 4-deep FIFO.
    busy_len = 3;
    clear_all();
    for (int k = 0; k < 6; k++) begin
      add_exp(s6[k]);
      push_sample(s6[k]);
      if (k == 3) begin
        check_eq("burst_ready_after4", 32'(sample_ready), 1);
        check_eq("burst_level_after4", 32'(fifo_level), 3);
      end
      if (k == 4) begin
        check_eq("burst_ready_after5", 32'(sample_ready), 0);
        check_eq("burst_level_after5", 32'(fifo_level), 4);
      end
    end
    sample_valid = 1'b0;
    wait_done(6 * NBT, 3000);
    check_bytes("burst_byte");

    // Busy never rises: bytes advance on the timeout.
    busy_len = 0;
    clear_all();
    add_exp(16'hBEEF);
    push_sample(16'hBEEF);
    sample_valid = 1'b0;
    wait_done(NBT, 400);
    check_bytes("tmo_byte");
    if (got_cyc.size() >= 2) begin
      gap = got_cyc[1] - got_cyc[0];
      check_eq("tmo_gap", 32'(gap >= BUSY_TMO + 2 && gap <= BUSY_TMO + 3), 1);
    end

    // Reset while later bytes of 16'hCAFE are still pending.
    busy_len = 20;
    clear_all();
    push_sample(16'hCAFE);
    sample_valid = 1'b0;
    for (int i = 0; i < 200 && got.size() < 1; i++) @(negedge clk);
    check_eq("rst_first_byte_seen", 32'(got.size() >= 1), 1);
    repeat (5) @(negedge clk);
    n0  = got.size();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("midrst_no_more_bytes", got.size(), n0);
    for (int i = 0; i < got.size(); i++) check_eq("midrst_no_CA", 32'(got[i] == 8'hCA), 0);
    check_eq("midrst_idle_after", 32'(idle), 1);
    check_eq("midrst_level_after", 32'(fifo_level), 0);

    // Push and pop coincide while the FIFO holds two samples.
    busy_len = 2;
    clear_all();
    add_exp(16'h0102);
    add_exp(16'h0304);
    add_exp(16'h0506);
    push_sample(16'h0102);
    check_eq("pp_level1", 32'(fifo_level), 1);
    push_sample(16'h0304);
    check_eq("pp_level2", 32'(fifo_level), 2);
    push_sample(16'h0506);
    sample_valid = 1'b0;
    check_eq("pp_level_push_pop", 32'(fifo_level), 2);
    wait_done(3 * NBT, 1000);
    check_bytes("pp_byte");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
